// File: rtl/psum_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psum_out_ctrl
// Purpose  : Drains partial-sum rows, requantizes each column to int8 and
//            emits bytes with their HWC output address.
// Revision : 1.0 - initial release
// ============================================================================
module psum_out_ctrl #(
    parameter int PSUM_BW  = 32,
    parameter int NUM_COLS = 32,
    parameter int ADDR_OUT = 20
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [7:0]                  OC,
    input  logic [5:0]                  IMG_H,
    input  logic [5:0]                  IMG_W,
    input  logic [15:0]                 q_mult,
    input  logic [4:0]                  q_shift,
    input  logic [7:0]                  q_zp,
    input  logic                        relu_en,
    input  logic [PSUM_BW*NUM_COLS-1:0] psum_rows,
    input  logic                        psum_rows_valid,
    output logic                        psum_rows_ready,
    output logic [7:0]                  out_data,
    output logic [ADDR_OUT-1:0]         out_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WAIT_ROW = 2'd1;
    localparam logic [1:0] c_ST_SEND     = 2'd2;
    localparam logic [1:0] c_ST_FIN      = 2'd3;

    localparam int         c_COLS_CAP_I = (NUM_COLS > 63) ? 63 : NUM_COLS;
    localparam logic [5:0] c_COLS_CAP   = 6'(c_COLS_CAP_I);
    localparam int         c_XPAD       = 48 - PSUM_BW;

    logic [1:0]                  r_state;
    logic [7:0]                  r_oc_n;
    logic [5:0]                  r_img_h;
    logic [5:0]                  r_img_w;
    logic [15:0]                 r_q_mult;
    logic [4:0]                  r_q_shift;
    logic [7:0]                  r_q_zp;
    logic                        r_relu_en;
    logic [PSUM_BW*NUM_COLS-1:0] r_rows;
    logic [7:0]                  r_oc;
    logic [5:0]                  r_h;
    logic [5:0]                  r_w;

    logic [5:0]          w_img_w_eff;
    logic                w_zero_job;
    logic                w_last_col;
    logic                w_last_h;
    logic                w_last_oc;
    logic [PSUM_BW-1:0]  w_psum;
    logic [PSUM_BW-1:0]  w_x;
    logic signed [47:0]  w_x48;
    logic signed [47:0]  w_m48;
    logic signed [47:0]  w_prod;
    logic signed [47:0]  w_rnd;
    logic signed [47:0]  w_shifted;
    logic signed [47:0]  w_biased;
    logic [7:0]          w_sat;
    logic [31:0]         w_lin;
    logic [31:0]         w_addr32;

    assign w_img_w_eff = (IMG_W > c_COLS_CAP) ? c_COLS_CAP : IMG_W;
    assign w_zero_job  = (OC == 8'd0) || (IMG_H == 6'd0) || (IMG_W == 6'd0);
    assign w_last_col  = (r_w == r_img_w - 6'd1);
    assign w_last_h    = (r_h == r_img_h - 6'd1);
    assign w_last_oc   = (r_oc == r_oc_n - 8'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_ST_IDLE;
            r_oc_n    <= '0;
            r_img_h   <= '0;
            r_img_w   <= '0;
            r_q_mult  <= '0;
            r_q_shift <= '0;
            r_q_zp    <= '0;
            r_relu_en <= 1'b0;
            r_rows    <= '0;
            r_oc      <= '0;
            r_h       <= '0;
            r_w       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_oc_n    <= OC;
                        r_img_h   <= IMG_H;
                        r_img_w   <= w_img_w_eff;
                        r_q_mult  <= q_mult;
                        r_q_shift <= q_shift;
                        r_q_zp    <= q_zp;
                        r_relu_en <= relu_en;
                        r_oc      <= '0;
                        r_h       <= '0;
                        r_w       <= '0;
                        r_state   <= w_zero_job ? c_ST_FIN : c_ST_WAIT_ROW;
                    end
                end
                c_ST_WAIT_ROW: begin
                    if (psum_rows_valid) begin
                        r_rows  <= psum_rows;
                        r_w     <= '0;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (out_ready) begin
                        if (w_last_col) begin
                            r_w <= '0;
                            // oc is the outer loop, h the inner one
                            if (w_last_h) begin
                                r_h <= '0;
                                if (w_last_oc) begin
                                    r_state <= c_ST_FIN;
                                end else begin
                                    r_oc    <= r_oc + 8'd1;
                                    r_state <= c_ST_WAIT_ROW;
                                end
                            end else begin
                                r_h     <= r_h + 6'd1;
                                r_state <= c_ST_WAIT_ROW;
                            end
                        end else begin
                            r_w <= r_w + 6'd1;
                        end
                    end
                end
                c_ST_FIN: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_psum = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_w == 6'(c)) begin
                w_psum = r_rows[c*PSUM_BW +: PSUM_BW];
            end
        end
    end

    // Round-half-up before the arithmetic shift, then add the zero point
    assign w_x       = (r_relu_en && w_psum[PSUM_BW-1]) ? '0 : w_psum;
    assign w_x48     = {{c_XPAD{w_x[PSUM_BW-1]}}, w_x};
    assign w_m48     = {{32{r_q_mult[15]}}, r_q_mult};
    assign w_prod    = w_x48 * w_m48;
    assign w_rnd     = (r_q_shift != 5'd0) ? (48'sd1 <<< (r_q_shift - 5'd1)) : 48'sd0;
    assign w_shifted = (w_prod + w_rnd) >>> r_q_shift;
    assign w_biased  = w_shifted + {{40{r_q_zp[7]}}, r_q_zp};

    always_comb begin
        if (w_biased > 48'sd127) begin
            w_sat = 8'h7F;
        end else if (w_biased < -48'sd128) begin
            w_sat = 8'h80;
        end else begin
            w_sat = w_biased[7:0];
        end
    end

    assign w_lin    = 32'(r_h) * 32'(r_img_w) + 32'(r_w);
    assign w_addr32 = w_lin * 32'(r_oc_n) + 32'(r_oc);

    assign psum_rows_ready = (r_state == c_ST_WAIT_ROW);
    assign out_valid       = (r_state == c_ST_SEND);
    assign done            = (r_state == c_ST_FIN);
    assign out_data        = out_valid ? w_sat : 8'd0;
    assign out_addr        = out_valid ? ADDR_OUT'(w_addr32) : '0;

endmodule
`default_nettype wire

// File: tb/tb_psum_out_ctrl.sv
`default_nettype none
// Testbench for psum_out_ctrl: table-driven single-row jobs plus multi-row,
// clamping, degenerate, backpressure and mid-job reset sequences.
module tb_psum_out_ctrl;

    localparam int PB = 32;
    localparam int NC = 8;
    localparam int AW = 20;
    localparam int NV = 7;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [7:0]       OC;
    logic [5:0]       IMG_H;
    logic [5:0]       IMG_W;
    logic [15:0]      q_mult;
    logic [4:0]       q_shift;
    logic [7:0]       q_zp;
    logic             relu_en;
    logic [PB*NC-1:0] psum_rows;
    logic             psum_rows_valid;
    logic             psum_rows_ready;
    logic [7:0]       out_data;
    logic [AW-1:0]    out_addr;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             done;

    always #5 clk = ~clk;

    psum_out_ctrl #(.PSUM_BW(PB), .NUM_COLS(NC), .ADDR_OUT(AW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .OC(OC), .IMG_H(IMG_H),
        .IMG_W(IMG_W), .q_mult(q_mult), .q_shift(q_shift), .q_zp(q_zp),
        .relu_en(relu_en), .psum_rows(psum_rows), .psum_rows_valid(psum_rows_valid),
        .psum_rows_ready(psum_rows_ready), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    typedef struct {
        logic [7:0]    data;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct {
        int oc, h, w, mult, sh, zp;
        bit relu;
        logic [2:0][31:0] ps;
        logic [2:0][7:0]  ex;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NV];

    int checks = 0, failures = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, bytes_rx = 0, rowrdy_cnt = 0, stall_seen = 0;
    int rdy_mode = 0, stall_cnt = 0, stall_trigger = -1;
    logic          prev_stall = 1'b0;
    logic [7:0]    prev_data;
    logic [AW-1:0] prev_addr;
    exp_t          me;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] qref(input longint psum, input int mult, input int sh,
                                        input int zp, input bit relu);
        longint x, p;
        x = (relu && psum < 0) ? 0 : psum;
        p = x * mult;
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        p = p >>> sh;
        p = p + zp;
        if (p > 127) p = 127;
        else if (p < -128) p = -128;
        return p[7:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rdy_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor: scoreboard pops, hold-stability and mutual exclusion
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_seen++;
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_addr", 64'(out_addr), 64'(prev_addr));
            end
            if (out_valid) check("ready_excl", 64'(psum_rows_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 64'(sb_q.size()), 64'(1));
                end else begin
                    me = sb_q.pop_front();
                    check("out_data", 64'(out_data), 64'(me.data));
                    check("out_addr", 64'(out_addr), 64'(me.addr));
                end
                bytes_rx++;
                if (bytes_rx == stall_trigger) stall_cnt = 5;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (psum_rows_ready) rowrdy_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
        end
    end

    task automatic setv(input int i, input int oc, input int h, input int w, input int mult,
                        input int sh, input int zp, input bit relu,
                        input int p0, input int p1, input int p2,
                        input int e0, input int e1, input int e2);
        vecs[i].oc = oc; vecs[i].h = h; vecs[i].w = w;
        vecs[i].mult = mult; vecs[i].sh = sh; vecs[i].zp = zp; vecs[i].relu = relu;
        vecs[i].ps[0] = p0; vecs[i].ps[1] = p1; vecs[i].ps[2] = p2;
        vecs[i].ex[0] = 8'(e0); vecs[i].ex[1] = 8'(e1); vecs[i].ex[2] = 8'(e2);
    endtask

    task automatic run_job(input int oc, input int h, input int w, input int mult,
                           input int sh, input int zp, input bit relu,
                           input int tbl, input bit chk_lat);
        int weff, rows, start_cyc, d0, b0, r0, k;
        longint psv[NC];
        logic [PB*NC-1:0] row;
        exp_t e;
        weff = (w > NC) ? NC : w;
        rows = (oc == 0 || h == 0 || w == 0) ? 0 : oc * h;
        d0 = done_cnt; b0 = bytes_rx; r0 = rowrdy_cnt;
        @(posedge clk); #1;
        OC = 8'(oc); IMG_H = 6'(h); IMG_W = 6'(w);
        q_mult = 16'(mult); q_shift = 5'(sh); q_zp = 8'(zp); relu_en = relu;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int oi = 0; oi < oc && rows > 0; oi++) begin
            for (int hi = 0; hi < h; hi++) begin
                for (int c = 0; c < NC; c++) begin
                    if (tbl >= 0 && c < 3) psv[c] = longint'($signed(vecs[tbl].ps[c]));
                    else psv[c] = longint'(int'($urandom_range(0, 200000)) - 100000);
                    row[c*PB +: PB] = psv[c][PB-1:0];
                end
                psum_rows = row;
                psum_rows_valid = 1'b1;
                k = 0;
                do begin @(negedge clk); #1; k++; end while (!psum_rows_ready && k < 200);
                if (!psum_rows_ready) begin
                    check("row_timeout", 64'(psum_rows_ready), 64'(1));
                    psum_rows_valid = 1'b0;
                    return;
                end
                for (int wi = 0; wi < weff; wi++) begin
                    e.data = (tbl >= 0) ? vecs[tbl].ex[wi] : qref(psv[wi], mult, sh, zp, relu);
                    e.addr = AW'((hi * weff + wi) * oc + oi);
                    sb_q.push_back(e);
                end
                @(posedge clk); #1;
                psum_rows_valid = 1'b0;
            end
        end
        k = 0;
        while (done_cnt == d0 && k < 1000) begin @(negedge clk); #1; k++; end
        check("done_seen", 64'(done_cnt - d0), 64'(1));
        if (chk_lat) check("latency", 64'(done_cyc - start_cyc), 64'(1 + rows * (1 + weff)));
        repeat (3) begin @(negedge clk); #1; end
        check("done_once", 64'(done_cnt - d0), 64'(1));
        check("byte_count", 64'(bytes_rx - b0), 64'(rows * weff));
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        if (rows == 0) check("no_row_ready", 64'(rowrdy_cnt - r0), 64'(0));
    endtask

    initial begin
        int d0, b0, r0, k;
        longint psv[NC];
        logic [PB*NC-1:0] row;
        exp_t e;

        resetn = 1'b0; start = 1'b0; OC = '0; IMG_H = '0; IMG_W = '0;
        q_mult = '0; q_shift = '0; q_zp = '0; relu_en = 1'b0;
        psum_rows = '0; psum_rows_valid = 1'b0;

        setv(0, 1, 1, 2,     1,  3,    0, 0,    1000,   -1000,  0,  125, -125,   0);
        setv(1, 1, 1, 3,     1,  0,    0, 0,  100000, -100000, -5,  127, -128,  -5);
        setv(2, 1, 1, 3,     1,  0,    3, 1,  100000, -100000, -5,  127,    3,   3);
        setv(3, 1, 1, 3,    -3,  2,  -10, 0,      10,     -10,  7,  -17,   -2, -15);
        setv(4, 1, 1, 2, 16384, 31,    0, 0, 1048576,-1048576,  0,    8,   -8,   0);
        setv(5, 1, 1, 2,     1,  0, -128, 0,       0,      -1,  0, -128, -128,   0);
        setv(6, 1, 1, 3,     1,  1,    0, 0,       3,      -3,  1,    2,   -1,   1);

        repeat (3) @(negedge clk);
        check("rst_rows_ready", 64'(psum_rows_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_addr", 64'(out_addr), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        resetn = 1'b1;
        psum_rows_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_ready", 64'(psum_rows_ready), 64'(0));
        psum_rows_valid = 1'b0;

        for (int i = 0; i < NV; i++)
            run_job(vecs[i].oc, vecs[i].h, vecs[i].w, vecs[i].mult, vecs[i].sh,
                    vecs[i].zp, vecs[i].relu, i, 1'b1);

        run_job(2, 2, 4, 37, 6, -5, 1'b0, -1, 1'b1);
        run_job(1, 2, 10, 5, 4, 7, 1'b0, -1, 1'b1);
        run_job(1, 0, 4, 1, 0, 0, 1'b0, -1, 1'b1);
        run_job(0, 2, 4, 1, 0, 0, 1'b0, -1, 1'b1);
        run_job(3, 1, 0, 1, 0, 0, 1'b0, -1, 1'b1);

        k = stall_seen;
        stall_trigger = bytes_rx + 2;
        run_job(1, 2, 6, 9, 5, 1, 1'b0, -1, 1'b0);
        stall_trigger = -1;
        check("stall_cycles_ge5", 64'(stall_seen - k >= 5), 64'(1));

        rdy_mode = 1;
        run_job(3, 2, 5, -21, 8, 2, 1'b1, -1, 1'b0);
        rdy_mode = 0;

        // Reset in the middle of the second byte of row 0
        d0 = done_cnt; b0 = bytes_rx;
        @(posedge clk); #1;
        OC = 8'd1; IMG_H = 6'd1; IMG_W = 6'd4;
        q_mult = 16'd1; q_shift = 5'd0; q_zp = 8'd0; relu_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < NC; c++) begin
            psv[c] = longint'(c * 10 - 15);
            row[c*PB +: PB] = psv[c][PB-1:0];
        end
        psum_rows = row;
        psum_rows_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!psum_rows_ready && k < 50);
        check("rj_row_ready", 64'(psum_rows_ready), 64'(1));
        for (int wi = 0; wi < 4; wi++) begin
            e.data = qref(psv[wi], 1, 0, 0, 1'b0);
            e.addr = AW'(wi);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        psum_rows_valid = 1'b0;
        k = 0;
        while (bytes_rx - b0 < 1 && k < 50) begin @(negedge clk); #1; k++; end
        @(posedge clk); #2;
        check("rj_mid_valid", 64'(out_valid), 64'(1));
        check("rj_mid_addr", 64'(out_addr), 64'(1));
        resetn = 1'b0;
        #1;
        check("rj_rows_ready", 64'(psum_rows_ready), 64'(0));
        check("rj_out_valid", 64'(out_valid), 64'(0));
        check("rj_out_data", 64'(out_data), 64'(0));
        check("rj_out_addr", 64'(out_addr), 64'(0));
        check("rj_done", 64'(done), 64'(0));
        sb_q.delete();
        psum_rows_valid = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        r0 = rowrdy_cnt;
        repeat (5) begin @(negedge clk); #1; end
        check("rj_no_ready_after", 64'(rowrdy_cnt - r0), 64'(0));
        check("rj_no_done", 64'(done_cnt - d0), 64'(0));
        psum_rows_valid = 1'b0;

        run_job(2, 1, 3, 3, 2, -4, 1'b0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_out_ctrl.md
PSUM_OUT_CTRL -- requirements
Module: psum_out_ctrl

Interface
REQ-001 Parameter PSUM_BW, default 32, SHALL set the bit width of one partial sum.
REQ-002 Parameter NUM_COLS, default 32, SHALL set the number of partial sums per row beat.
REQ-003 Parameter ADDR_OUT, default 20, SHALL set the output byte address width.
REQ-004 Port clk, input, 1, is the single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port resetn, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Port start, input, 1, is a one-cycle pulse that starts a drain job.
REQ-007 Port OC, input, 8, is the output-channel count of the tile.
REQ-008 Port IMG_H, input, 6, is the output height of the tile.
REQ-009 Port IMG_W, input, 6, is the output width of the tile.
REQ-010 Port q_mult, input, 16, is the signed requantization multiplier.
REQ-011 Port q_shift, input, 5, is the unsigned right-shift amount (0..31).
REQ-012 Port q_zp, input, 8, is the signed output zero point.
REQ-013 Port relu_en, input, 1, enables ReLU.
REQ-014 Port psum_rows, input, PSUM_BW*NUM_COLS, carries one row of signed partial sums; column c occupies bits [PSUM_BW*(c+1)-1 : PSUM_BW*c].
REQ-015 Port psum_rows_valid, input, 1, marks psum_rows as valid.
REQ-016 Port psum_rows_ready, output, 1, accepts a row when it is high together with psum_rows_valid.
REQ-017 Port out_data, output, 8, carries the signed int8 result.
REQ-018 Port out_addr, output, ADDR_OUT, carries the HWC byte address of out_data.
REQ-019 Port out_valid, output, 1; Port out_ready, input, 1: a byte transfers when both are high.
REQ-020 Port done, output, 1, pulses for one cycle when the job completes.

Function
REQ-021 The FSM SHALL have the states IDLE, WAIT_ROW, SEND and FIN.
REQ-022 In IDLE, a start pulse SHALL latch OC, IMG_H, IMG_W and the quantization inputs and move the FSM to WAIT_ROW; start in any other state SHALL be ignored.
REQ-023 If OC, IMG_H or IMG_W equals 0 at start, the FSM SHALL go straight to FIN with no row or byte transfers.
REQ-024 IMG_W values above NUM_COLS SHALL be treated as NUM_COLS.
REQ-025 psum_rows_ready SHALL be high only in WAIT_ROW.
REQ-026 On a row handshake the block SHALL register all NUM_COLS partial sums, set column w=0 and move to SEND.
REQ-027 Row order SHALL be oc outer, h inner, giving OC*IMG_H rows per job.
REQ-028 In SEND, out_valid SHALL be high for columns w = 0 .. IMG_W-1; out_data and out_addr SHALL stay stable until the handshake.
REQ-029 The first out_valid SHALL be asserted in the cycle after the row handshake, and each later byte SHALL follow in the cycle after the previous byte's handshake, so that with out_ready held high one byte transfers per cycle.
REQ-030 out_addr SHALL equal (h*IMG_W + w)*OC + oc, truncated to ADDR_OUT bits.
REQ-031 Each byte SHALL be computed as follows:
- x = (relu_en && psum<0) ? 0 : psum;
- p = x*q_mult as a 48-bit signed product;
- if q_shift>0, p = p + 2^(q_shift-1);
- r = p >>> q_shift (arithmetic shift);
- r = r + q_zp (sign-extended);
- r is saturated to [-128, 127].
REQ-032 After the handshake of the last column, the FSM SHALL go to WAIT_ROW if rows remain, otherwise to FIN.
REQ-033 FIN SHALL assert done for exactly one cycle and then return to IDLE.

Reset
REQ-034 While resetn=0, the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-035 While resetn=0, the outputs SHALL be: psum_rows_ready=0, out_valid=0, out_data=0, out_addr=0, done=0.
REQ-036 A reset asserted mid-job SHALL abort the job immediately without asserting done.
REQ-037 After reset deasserts, the block SHALL need a new start pulse before it accepts any row.

Verification
REQ-038 Rounding: OC=1, IMG_H=1, IMG_W=2, q_mult=1, q_shift=3, q_zp=0, psums {1000, -1000} -> out_data {125, -125}, out_addr {0, 1}, then done.
REQ-039 Saturation and ReLU: q_shift=0, q_mult=1, psums {100000, -100000, -5}; relu_en=0 -> {127, -128, -5}; relu_en=1 with q_zp=3 -> {127, 3, 3}.
REQ-040 Address order: OC=2, IMG_H=2, IMG_W=4 -> 4 rows and 16 bytes; row 1 (oc=0, h=1) w=0 gives addr 8; row 2 (oc=1, h=0) w=3 gives addr 7; done follows the 16th byte.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles mid-row -> out_valid stays 1 with data and address unchanged, psum_rows_ready stays 0, and no byte is lost or duplicated.
REQ-042 Degenerate job: start with IMG_H=0 -> no out_valid and no psum_rows_ready; done pulses once; the FSM returns to IDLE.
REQ-043 Reset mid-job: drop resetn during byte 2 of row 0 -> all outputs go to 0 immediately and done never asserts; a new start then runs a full job correctly.
